mult_4_bit_seq_ctrl_v: RTL

MULT_4_BIT_SEQ_CTRL_V -- requirements
Module: mult_4_bit_seq_ctrl_v

---
 rtl/mult_pkg.sv | 16 +
 rtl/binary_4_bit_adder_v.sv | 20 ++
 rtl/mult_4_bit_seq_ctrl_v.sv | 108 ++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the 4-bit sequential shift-add multiplier.
package mult_pkg;

   localparam int OP_W  = 4;
   localparam int STEPS = 4;

   // Counter value on which the final shift-add step is taken.
   localparam logic [1:0] LAST_STEP = 2'(STEPS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/binary_4_bit_adder_v.sv
// 4-bit unsigned ripple adder with carry-in and carry-out.
module binary_4_bit_adder_v (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [4:0] total;

   // Full 5-bit sum so the carry is never lost.
   always_comb begin
      total = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
   end

   assign sum  = total[3:0];
   assign cout = total[4];

endmodule

// File: rtl/mult_4_bit_seq_ctrl_v.sv
// Sequential 4x4 unsigned multiplier: one shift-add step per clock,
// four steps per operation, result presented for one DONE cycle.
module mult_4_bit_seq_ctrl_v
   import mult_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic [3:0] i_au,
   input  logic [3:0] i_bu,
   output logic       o_busy,
   output logic       o_done,
   output logic [7:0] o_fu
);

   state_t              state;
   state_t              state_nxt;
   logic [OP_W-1:0]     a_reg;
   logic [OP_W-1:0]     b_reg;
   logic [2*OP_W:0]     prod;
   logic [1:0]          cnt;
   logic [2*OP_W-1:0]   fu;

   logic [OP_W-1:0]     add_b;
   logic [OP_W-1:0]     add_sum;
   logic                add_cout;
   logic [2*OP_W:0]     prod_step;
   logic                accept;
   logic                last_step;
   logic                unused_carry;

   // The adder sees the multiplicand only when the current multiplier LSB is set.
   assign add_b = b_reg[0] ? a_reg : '0;

   binary_4_bit_adder_v u_adder (
      .a    (prod[7:4]),
      .b    (add_b),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // Carry lands in bit 8 of the sum, then the whole {carry, product} shifts right.
   assign prod_step = {1'b0, add_cout, add_sum, prod[3:1]};

   // Bit 8 always holds zero after the shift and never feeds the next add.
   assign unused_carry = prod[8];

   // Next-state and registered-state output decode.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      last_step = 1'b0;
      o_busy    = 1'b0;
      o_done    = 1'b0;
      case (state)
         IDLE: begin
            if (i_start) begin
               accept    = 1'b1;
               state_nxt = CALC;
            end
         end
         CALC: begin
            o_busy = 1'b1;
            if (cnt == LAST_STEP) begin
               last_step = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            o_busy    = 1'b1;
            o_done    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, operand, partial-product and result registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
         a_reg <= '0;
         b_reg <= '0;
         prod  <= '0;
         cnt   <= '0;
         fu    <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            a_reg <= i_au;
            b_reg <= i_bu;
            prod  <= '0;
            cnt   <= '0;
         end else if (state == CALC) begin
            prod  <= prod_step;
            b_reg <= b_reg >> 1;
            cnt   <= cnt + 2'd1;
            if (last_step) begin
               fu <= prod_step[2*OP_W-1:0];
            end
         end
      end
   end

   assign o_fu = fu;

endmodule
